// File: rtl/seg_pkg.sv
// Shared types and segment encodings for the 7-segment scan driver.
// Pure definitions; no latency, no flow control.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    // Active-low encodings, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = ~7'h3F;
            4'd1:    seg = ~7'h06;
            4'd2:    seg = ~7'h5B;
            4'd3:    seg = ~7'h4F;
            4'd4:    seg = ~7'h66;
            4'd5:    seg = ~7'h6D;
            4'd6:    seg = ~7'h7D;
            4'd7:    seg = ~7'h07;
            4'd8:    seg = ~7'h7F;
            4'd9:    seg = ~7'h67;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < 9; i++) begin
            if (i < n) begin
                r = r * 32'd10;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: captures on load, VALUE_W steps, one commit cycle.
// busy high VALUE_W+1 cycles; load while busy is dropped, never queued.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VALUE_W-1:0]      value_i,
    input  logic                    load_i,
    output logic                    busy_o,
    output logic                    ovf_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int          BCD_W = 4 * NUM_DIGITS;
    localparam int          ACC_W = BCD_W + 4;
    localparam int          CNT_W = $clog2(VALUE_W + 1);
    localparam logic [31:0] LIMIT = pow10(NUM_DIGITS);

    state_t                 state_q;
    logic [VALUE_W-1:0]     bin_q;
    logic [ACC_W-1:0]       acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;
    logic                   ovf_pend_q;
    logic                   ovf_q;
    logic [BCD_W-1:0]       bcd_q;

    logic [ACC_W-1:0]         acc_adj;
    logic [ACC_W+VALUE_W-1:0] shifted;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < ACC_W / 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {acc_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        bin_q      <= value_i;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        // Decided on the binary value so the guard nibble never matters
                        ovf_pend_q <= (32'(value_i) >= LIMIT);
                        busy_q     <= 1'b1;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_q <= shifted[ACC_W+VALUE_W-1 -: ACC_W];
                    bin_q <= shifted[VALUE_W-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    bcd_q   <= acc_q[BCD_W-1:0];
                    ovf_q   <= ovf_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign ovf_o  = ovf_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit 7-segment driver: BCD convert, atomic commit, registered scan mux.
// New digits on seg two cycles after conversion ends; load ignored while busy.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int   BCD_W    = 4 * NUM_DIGITS;
    localparam int   DIV_W    = $clog2(REFRESH_DIV);
    localparam int   IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic BLANK_EN = (BLANK_LEADING != 0);

    logic [BCD_W-1:0]      bcd;
    logic                  ovf;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            nib;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .VALUE_W    (VALUE_W)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .value_i (value),
        .load_i  (load),
        .busy_o  (busy),
        .ovf_o   (ovf),
        .bcd_o   (bcd)
    );

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // A digit is leading when it and every digit above it are zero
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank[i] = BLANK_EN && (i > 0) && ((bcd >> (4 * i)) == '0);
            an_d[i]  = (idx_q != IDX_W'(i));
        end

        nib = 4'(bcd >> {idx_q, 2'b00});

        if (ovf) begin
            seg_d = SEG_DASH;
        end else if (blank[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = bcd_to_seg(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign overflow = ovf;

endmodule
